ram_soc_master: RTL
===================

# ram_soc_master

Request-side sequencer for the four-chip dual-port RAM subsystem. It accepts single or burst read/write commands from a client over valid/ready handshakes and drives the subsystem's read port and write port. It returns read data beat by beat and signals burst completion or a read timeout. It is the initiator the RAM subsystem responds to, and the only agent allowed to drive its read/write strobes.

## Interface
- RAM_WIDTH, 64, data width; matches the RAM subsystem.
- ADDR_SIZE, 14, address width; the upper 2 bits select the chip inside the subsystem.
- LEN_W, 4, burst length field width; beats = cmd_len + 1 (1..16).
- TIMEOUT, 15, maximum cycles in RD_ISSUE without mem_data_valid before abort.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_SIZE  start address.
- cmd_len  in  LEN_W  beats minus one.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write beat accepted.
- wr_data  in  RAM_WIDTH  write beat data.
- rd_valid  out  1  read beat present.
- rd_ready  in  1  client accepts read beat.
- rd_data  out  RAM_WIDTH  read beat data.
- rd_last  out  1  final beat of the burst (qualified by rd_valid).
- done  out  1  one-cycle pulse at burst end.
- err  out  1  timeout flag; meaningful only with done.
- mem_read, mem_write  out  1  strobes to the RAM subsystem.
- mem_rd_address, mem_wr_address  out  ADDR_SIZE  RAM addresses.
- mem_data_in  out  RAM_WIDTH  RAM write data.
- mem_data_out  in  RAM_WIDTH  RAM read data.
- mem_data_valid  in  1  RAM read data valid.

## Operation
- States: IDLE, WR_WAIT, WR_ISSUE, RD_ISSUE, RD_HOLD, DONE.
- IDLE
  - cmd_ready=1.
  - On accept, latch addr, remaining-beat count (cmd_len) and direction, clear err.
  - Go to WR_WAIT if cmd_write=1, otherwise RD_ISSUE.
- WR_WAIT
  - wr_ready=1.
  - On wr_valid, register wr_data into mem_data_in and addr into mem_wr_address, then go to WR_ISSUE.
- WR_ISSUE
  - mem_write=1 for exactly one cycle.
  - addr increments and the count decrements.
  - Go to WR_WAIT if beats remain, otherwise DONE.
- RD_ISSUE
  - mem_read=1 and mem_rd_address=addr are held until mem_data_valid=1 is sampled.
  - On that cycle, capture mem_data_out into rd_data, set rd_valid, and go to RD_HOLD.
  - mem_read drops the next cycle.
- RD_HOLD
  - rd_valid is held with stable rd_data and rd_last until rd_ready=1.
  - On acceptance, addr increments; go to RD_ISSUE if beats remain, otherwise DONE.
  - No new read is issued while a beat is unaccepted.
- Timeout
  - A counter clears on entry to RD_ISSUE and counts each RD_ISSUE cycle.
  - If it reaches TIMEOUT with no mem_data_valid, drop mem_read, set err=1 and go to DONE.
  - Remaining beats are discarded and no rd_valid is produced for them.
- DONE: done=1 for one cycle, err held alongside, then return to IDLE.
- mem_read and mem_write are never both high.
- mem_data_valid is ignored outside RD_ISSUE.
- Address arithmetic: addr+1 mod 2^ADDR_SIZE.
  - 0x0FFF→0x1000 crosses from chip 0 to chip 1 with no special handling.
  - 0x3FFF wraps to 0x0000.
- A write burst stalls indefinitely without wr_valid; there is no write timeout.

## Timing
- Reset: state=IDLE; cmd_ready, wr_ready, rd_valid, rd_last, done, err, mem_read and mem_write are all 0; mem addresses, mem_data_in and rd_data are 0. cmd_ready rises the first cycle after rst deasserts.
- All outputs are registered, except that cmd_ready and wr_ready decode directly from state.
- Write latency: handshake at cycle N puts mem_write=1 at N+1 and wr_ready=1 again at N+2. Maximum throughput is one beat per 2 cycles.
- Read: command accepted at N gives mem_read=1 from N+1. If mem_data_valid is sampled at cycle M, rd_valid=1 from M+1.
- Last beat: the last write issue or last read acceptance at cycle K gives done at K+1 and cmd_ready at K+2.
- rst during any state aborts the burst at the next edge. No done pulse is emitted and the strobes drop immediately.

## Test plan
- Single write: cmd(write, addr 0x0005, len 0) plus wr_data 0xDEADBEEF_00000001 → one mem_write cycle at 0x0005 with that data, then done=1 and err=0.
- Read-back: cmd(read, 0x0005, len 0) with the RAM model returning valid after 3 cycles → rd_data=0xDEADBEEF_00000001, rd_last=1, done=1.
- Burst across chips: write 4 beats at 0x0FFE → mem_wr_address sequence 0x0FFE, 0x0FFF, 0x1000, 0x1001; a 4-beat read-back returns identical data, rd_last only on beat 4.
- Wrap plus backpressure: read 2 beats at 0x3FFF with rd_ready low for 5 cycles → addresses 0x3FFF then 0x0000; rd_data stable while stalled; second mem_read only after acceptance.
- Timeout: a read with mem_data_valid tied low → mem_read high for exactly 15 cycles, then done=1, err=1, no rd_valid.
- Reset mid-burst: rst pulsed during RD_ISSUE of beat 2 of 8 → mem_read=0 and rd_valid=0 the next cycle, no done, cmd_ready=1 one cycle after rst falls.

Source files
------------

// File: rtl/ram_soc_master.sv
// Request-side sequencer for the four-chip dual-port RAM subsystem: turns client
// single/burst commands into one-beat-at-a-time RAM read/write strobes.
module ram_soc_master #(
  parameter int RAM_WIDTH = 64,
  parameter int ADDR_SIZE = 14,
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [RAM_WIDTH-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic                 rd_last,
  output logic                 done,
  output logic                 err,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_SIZE-1:0] mem_rd_address,
  output logic [ADDR_SIZE-1:0] mem_wr_address,
  output logic [RAM_WIDTH-1:0] mem_data_in,
  input  logic [RAM_WIDTH-1:0] mem_data_out,
  input  logic                 mem_data_valid
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_WAIT, S_WR_ISSUE, S_RD_ISSUE, S_RD_HOLD, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [LEN_W-1:0]     r_cnt;
  logic [TMR_W-1:0]     r_tmr;
  logic                 r_mem_read, r_mem_write, r_rd_valid, r_rd_last, r_done, r_err;
  logic [ADDR_SIZE-1:0] r_mem_rd_address, r_mem_wr_address;
  logic [RAM_WIDTH-1:0] r_mem_data_in, r_rd_data;
  logic                 w_cmd_acc, w_last, w_tmo;

  assign w_cmd_acc = cmd_valid && cmd_ready;
  assign w_last    = (r_cnt == '0);
  assign w_tmo     = (r_tmr == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // cmd_ready is masked while rst is held so it only rises once reset is released
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) w_next = cmd_write ? S_WR_WAIT : S_RD_ISSUE;
      end
      S_WR_WAIT: begin
        wr_ready = 1'b1;
        if (wr_valid) w_next = S_WR_ISSUE;
      end
      S_WR_ISSUE: w_next = w_last ? S_DONE : S_WR_WAIT;
      S_RD_ISSUE: begin
        if (mem_data_valid) w_next = S_RD_HOLD;
        else if (w_tmo)     w_next = S_DONE;
      end
      S_RD_HOLD: begin
        if (rd_ready) w_next = w_last ? S_DONE : S_RD_ISSUE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr           <= '0;
      r_cnt            <= '0;
      r_tmr            <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_rd_valid       <= 1'b0;
      r_rd_last        <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
      r_mem_rd_address <= '0;
      r_mem_wr_address <= '0;
      r_mem_data_in    <= '0;
      r_rd_data        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_acc) begin
            r_addr <= cmd_addr;
            r_cnt  <= cmd_len;
            r_err  <= 1'b0;
            if (!cmd_write) begin
              r_mem_read       <= 1'b1;
              r_mem_rd_address <= cmd_addr;
              r_tmr            <= '0;
            end
          end
        end
        S_WR_WAIT: begin
          if (wr_valid) begin
            r_mem_data_in    <= wr_data;
            r_mem_wr_address <= r_addr;
            r_mem_write      <= 1'b1;
          end
        end
        S_WR_ISSUE: begin
          r_mem_write <= 1'b0;
          r_addr      <= r_addr + 1'b1;
          if (w_last) r_done <= 1'b1;
          else        r_cnt  <= r_cnt - 1'b1;
        end
        // A response on the final timer cycle still wins over the abort
        S_RD_ISSUE: begin
          if (mem_data_valid) begin
            r_rd_data  <= mem_data_out;
            r_rd_valid <= 1'b1;
            r_rd_last  <= w_last;
            r_mem_read <= 1'b0;
          end else if (w_tmo) begin
            r_mem_read <= 1'b0;
            r_err      <= 1'b1;
            r_done     <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_RD_HOLD: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_addr     <= r_addr + 1'b1;
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_cnt            <= r_cnt - 1'b1;
              r_mem_read       <= 1'b1;
              r_mem_rd_address <= r_addr + 1'b1;
              r_tmr            <= '0;
            end
          end
        end
        S_DONE:  r_done <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_rd_address = r_mem_rd_address;
  assign mem_wr_address = r_mem_wr_address;
  assign mem_data_in    = r_mem_data_in;
  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_data;
  assign rd_last        = r_rd_last;
  assign done           = r_done;
  assign err            = r_err;

endmodule
